// File: rtl/risci_scoreboard.sv
// Register scoreboard: per-register saturating pending-write counters that gate issue on RAW hazards.
// Issue decision is combinational, and the counters update on the next edge. Issue stalls on a hazard, on a full counter, on flush or during reset.
module risci_scoreboard #(
  parameter int XWDT      = 6,
  parameter int NSRC      = 2,
  parameter int CNTW      = 2,
  parameter int R0_ZERO   = 1,
  parameter int WB_BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  output logic                   iss_ready,
  input  logic [NSRC*XWDT-1:0]   iss_rs,
  input  logic [NSRC-1:0]        iss_rs_used,
  input  logic [XWDT-1:0]        iss_rd,
  input  logic                   iss_rd_used,
  input  logic                   wb_valid,
  input  logic [XWDT-1:0]        wb_rd,
  input  logic                   flush,
  output logic [2**XWDT-1:0]     busy,
  output logic [XWDT+CNTW-1:0]   outstanding,
  output logic                   err
);

  localparam int NREG = 2**XWDT;
  localparam int OW   = XWDT + CNTW;
  localparam logic [CNTW-1:0] CMAX = '1;

  logic [CNTW-1:0] count [NREG];
  logic [OW-1:0]   outst;
  logic            err_q;

  logic [XWDT-1:0] rs_idx [NSRC];
  logic [NSRC-1:0] hz;
  logic            rd_track;
  logic            full;
  logic            fire;
  logic            inc_en;
  logic            wb_bad;
  logic            dec_en;

  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      rs_idx[k] = iss_rs[k*XWDT +: XWDT];
      hz[k]     = iss_rs_used[k] && (count[rs_idx[k]] != '0);
      if ((R0_ZERO != 0) && (rs_idx[k] == '0))
        hz[k] = 1'b0;
      // A retiring writeback that drains the last pending write releases the operand this cycle.
      if ((WB_BYPASS != 0) && wb_valid && (wb_rd == rs_idx[k]) && (count[rs_idx[k]] == CNTW'(1)))
        hz[k] = 1'b0;
    end
  end

  assign rd_track  = iss_rd_used && !((R0_ZERO != 0) && (iss_rd == '0));
  assign full      = rd_track && (count[iss_rd] == CMAX);
  assign iss_ready = rst && !flush && !(|hz) && !full;
  assign fire      = iss_valid && iss_ready;
  assign inc_en    = fire && rd_track;

  assign wb_bad = wb_valid && (((R0_ZERO != 0) && (wb_rd == '0)) || (count[wb_rd] == '0));
  assign dec_en = wb_valid && !wb_bad;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) count[r] <= '0;
      outst <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) count[r] <= '0;
      outst <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_en && (iss_rd == XWDT'(r)) && !(dec_en && (wb_rd == XWDT'(r))))
          count[r] <= count[r] + CNTW'(1);
        else if (dec_en && (wb_rd == XWDT'(r)) && !(inc_en && (iss_rd == XWDT'(r))))
          count[r] <= count[r] - CNTW'(1);
      end
      if (inc_en && !dec_en)
        outst <= outst + OW'(1);
      else if (dec_en && !inc_en)
        outst <= outst - OW'(1);
      if (wb_bad)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) busy[r] = (count[r] != '0);
  end

  assign outstanding = outst;
  assign err         = err_q;

endmodule

// File: doc/risci_scoreboard.md
# risci_scoreboard

Parametrised register scoreboard for the risci pipeline. It tracks outstanding writes per architectural register with saturating counters, which allows several in-flight writers per register. It gates instruction issue on RAW hazards, optionally bypasses same-cycle writeback releases, and supports a pipeline flush. It sits between decode and execute and replaces ad-hoc per-register lock bits with a single reusable block.

## Interface
Parameters:
- XWDT, 6, register index width; NREG = 2**XWDT registers.
- NSRC, 2, number of source-operand ports checked per issue.
- CNTW, 2, pending-counter width; max outstanding writes per register = 2**CNTW-1.
- R0_ZERO, 1, when 1 register 0 is never tracked: never busy, never counted.
- WB_BYPASS, 1, when 1 a same-cycle writeback that retires the last pending write clears the hazard for issue.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk).
- iss_valid  in  1  decode presents an instruction.
- iss_ready  out  1  issue accepted this cycle (combinational).
- iss_rs  in  NSRC*XWDT  source indices, port k at [k*XWDT +: XWDT].
- iss_rs_used  in  NSRC  per-port enable; unused ports never stall.
- iss_rd  in  XWDT  destination index.
- iss_rd_used  in  1  instruction writes iss_rd.
- wb_valid  in  1  writeback retires one write.
- wb_rd  in  XWDT  register retired.
- flush  in  1  discard all outstanding writes.
- busy  out  NREG  registered; bit r = (count[r]!=0).
- outstanding  out  XWDT+CNTW  registered sum of all counters.
- err  out  1  sticky protocol-error flag.

## Operation
- State: count[r] (CNTW bits) per register, outstanding, err.
- Hazard on source port k: iss_rs_used[k] && count[rs_k]!=0, excluded when R0_ZERO && rs_k==0. With WB_BYPASS, the hazard is also excluded when wb_valid && wb_rd==rs_k && count[rs_k]==1.
- Full: iss_rd_used && count[iss_rd]==2**CNTW-1 (ignored for rd 0 when R0_ZERO).
- iss_ready = rst && !flush && !any hazard && !full. It does not depend on iss_valid. Issue fires when iss_valid && iss_ready.
- Update per register r, computed each cycle: inc = issue fire && iss_rd_used && iss_rd==r; dec = wb_valid && wb_rd==r && count[r]!=0.
  - inc && dec: count unchanged.
  - inc only: count+1.
  - dec only: count-1.
- outstanding is updated with the same net delta (+1, -1, or 0). It never wraps because each counter is bounded.
- wb_valid with count[wb_rd]==0, or wb_rd==0 when R0_ZERO: no count change, err set to 1 and held until reset.
- flush=1: on the next edge all counts and outstanding go to 0. Issue and writeback that cycle are ignored (no err from writeback). err is preserved.
- Reset (rst==0 at posedge): all counts, busy, outstanding and err go to 0. iss_ready is 0 while rst==0. Reset mid-operation discards all pending writes with no err.

## Timing
- Issue decision: combinational, same cycle as inputs. Counter effect is visible from the next cycle.
- busy and outstanding: registered, reflect state after the edge. Latency from issue to busy bit = 1 cycle.
- Writeback release:
  - WB_BYPASS=1: a dependent issue can fire in the same cycle as the retiring writeback.
  - WB_BYPASS=0: the dependent issue fires 1 cycle later.
- Priority: reset > flush > (issue, writeback) evaluated concurrently.
- No multi-cycle handshakes. Decode holds its inputs stable while iss_ready==0.

## Test plan
- Reset/basic: hold rst=0 for 2 cycles → busy=0, outstanding=0, err=0, iss_ready=0. Release reset, issue rd=5 with no sources → iss_ready=1; the next cycle busy[5]=1 and outstanding=1.
- RAW stall plus bypass: after rd=5 is pending, issue rs0=5 (used). Expect iss_ready=0. Assert wb_valid, wb_rd=5 in the same cycle:
  - WB_BYPASS=1: iss_ready=1 that cycle.
  - WB_BYPASS=0: iss_ready=0 that cycle and 1 the next.
- Saturation, CNTW=2: issue rd=7 three times → count 3, then a 4th issue with rd=7 gives iss_ready=0. One writeback to 7 → the 4th issue is accepted the following cycle.
- Simultaneous inc/dec plus R0: with count[3]=1, issue rd=3 and writeback 3 in the same cycle → count[3] stays 1, outstanding unchanged. Issue rd=0 with R0_ZERO=1 → busy[0] stays 0, outstanding unchanged.
- Protocol error: wb_valid, wb_rd=9 with count 0 → err=1 next cycle and counts unchanged. err stays 1 after a flush and clears only on reset.
- Flush mid-operation: with 4 registers pending, assert flush together with iss_valid and wb_valid → iss_ready=0 that cycle. The next cycle all busy=0, outstanding=0, err unchanged.
